riscv_mdu: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register-file read ports.
- Takes rs1/rs2 operand values plus destination register index through a valid/ready handshake.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle.
- Returns the result and rd through a second valid/ready handshake toward the register-file write port.

---
 rtl/riscv_mdu.sv | 142 ++++++++++++++
 tb/tb_riscv_mdu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Normal ops deliver a result 34 edges after accept; divide-by-zero and signed overflow deliver after 1 edge.
module riscv_mdu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [ADDR_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [ADDR_W-1:0] out_rd,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_nxt;
  logic [2:0]          f3_q;
  logic                a_neg_q, b_neg_q;
  logic [XLEN-1:0]     mcand, dvsr, quo, rem;
  logic [2*XLEN-1:0]   prod;
  logic [5:0]          cnt;

  logic                accept, a_sgn, b_sgn, a_neg, b_neg;
  logic                div_zero, div_ovf, early;
  logic [XLEN-1:0]     mag_a, mag_b, early_res;
  logic [XLEN:0]       msum, shifted;
  logic                ge;
  logic [XLEN-1:0]     sub;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, fix_res;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // Operand decode and early-out detection on the incoming request
  always_comb begin
    a_sgn     = !(funct3[0] && (funct3[1] || funct3[2]));
    b_sgn     = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg     = a_sgn && op_a[XLEN-1];
    b_neg     = b_sgn && op_b[XLEN-1];
    mag_a     = a_neg ? (~op_a + 1'b1) : op_a;
    mag_b     = b_neg ? (~op_b + 1'b1) : op_b;
    div_zero  = funct3[2] && (op_b == '0);
    div_ovf   = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (&op_b);
    early     = div_zero || div_ovf;
    early_res = '0;
    if (div_zero)
      early_res = funct3[1] ? op_a : '1;
    else
      early_res = funct3[1] ? '0 : INT_MIN;
  end

  // Per-iteration datapath and final sign fix-up
  always_comb begin
    msum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    shifted = {rem, quo[XLEN-1]};
    ge      = (shifted >= {1'b0, dvsr});
    // Partial remainder stays below the divisor, so the low word of the difference is exact
    sub     = shifted[XLEN-1:0] - dvsr;
    prod_s  = (a_neg_q ^ b_neg_q) ? (~prod + 1'b1) : prod;
    quo_s   = (a_neg_q ^ b_neg_q) ? (~quo + 1'b1) : quo;
    rem_s   = a_neg_q ? (~rem + 1'b1) : rem;
    case (f3_q)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_s;
      default:                fix_res = rem_s;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = early ? DONE : CALC;
      CALC: if (cnt == 6'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      mcand    <= '0;
      dvsr     <= '0;
      prod     <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_rd   <= '0;
    end else if (!flush) begin
      if (accept) begin
        f3_q    <= funct3;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        mcand   <= mag_a;
        dvsr    <= mag_b;
        prod    <= {{XLEN{1'b0}}, mag_b};
        quo     <= mag_a;
        rem     <= '0;
        cnt     <= '0;
        out_rd  <= rd;
        if (early) out_data <= early_res;
      end else if (state == CALC) begin
        cnt <= cnt + 6'd1;
        if (f3_q[2]) begin
          rem <= ge ? sub : shifted[XLEN-1:0];
          quo <= {quo[XLEN-2:0], ge};
        end else begin
          prod <= {msum, prod[XLEN-1:1]};
        end
      end else if (state == FIX) begin
        out_data <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mdu.sv
// Scoreboard bench for riscv_mdu: table of RV32M ops, latency, stall, flush and reset checks.
module tb_riscv_mdu;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, out_data;
  logic [5:0]  rd, out_rd;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  riscv_mdu #(.XLEN(32), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] r);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("issue_ready", {63'd0, in_ready}, 64'd1);
    funct3   = f;
    op_a     = a;
    op_b     = b;
    rd       = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits for the result, optionally stalls it for `hold` cycles, then drains it
  task automatic collect(input string tag, input int hold);
    int   n = 1;
    exp_t e;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({tag, "_data"}, {32'd0, out_data}, {32'd0, e.data});
    chk({tag, "_rd"}, {58'd0, out_rd}, {58'd0, e.rd});
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      funct3   = 3'b000;
      op_a     = 32'h5;
      op_b     = 32'h6;
      rd       = 6'd33;
      @(negedge clk);
      chk({tag, "_hold_vld"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_hold_data"}, {32'd0, out_data}, {32'd0, e.data});
      chk({tag, "_hold_rd"}, {58'd0, out_rd}, {58'd0, e.rd});
      chk({tag, "_hold_rdy"}, {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drain_vld"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_drain_rdy"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] r, input logic [31:0] want,
                        input bit early, input int hold);
    exp_t e;
    e.data = want;
    e.rd   = r;
    e.lat  = early ? 1 : 34;
    sb.push_back(e);
    issue(f, a, b, r);
    collect(tag, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_rd", {58'd0, out_rd}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;

    run_op("mul",    3'b000, 32'h7,        32'hFFFFFFFD, 6'd5,  32'hFFFFFFEB, 0, 0);
    run_op("mul_nn", 3'b000, 32'hFFFFFFFE, 32'hFFFFFFFD, 6'd12, 32'h00000006, 0, 0);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 6'd1,  32'h40000000, 0, 0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2,  32'hFFFFFFFF, 0, 0);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3,  32'hFFFFFFFE, 0, 0);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'h2,        6'd4,  32'hFFFFFFFD, 0, 0);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'h2,        6'd6,  32'hFFFFFFFF, 0, 0);
    run_op("div_nb", 3'b100, 32'h7,        32'hFFFFFFFE, 6'd14, 32'hFFFFFFFD, 0, 0);
    run_op("rem_nb", 3'b110, 32'h7,        32'hFFFFFFFE, 6'd15, 32'h00000001, 0, 0);
    run_op("divu",   3'b101, 32'd100,      32'd7,        6'd7,  32'd14,       0, 0);
    run_op("remu",   3'b111, 32'd100,      32'd7,        6'd0,  32'd2,        0, 0);
    run_op("divu_z", 3'b101, 32'h1234,     32'h0,        6'd8,  32'hFFFFFFFF, 1, 0);
    run_op("rem_z",  3'b110, 32'h1234,     32'h0,        6'd9,  32'h00001234, 1, 0);
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 6'd10, 32'h80000000, 1, 0);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 6'd11, 32'h00000000, 1, 0);
    run_op("stall",  3'b011, 32'h00010000, 32'h00010000, 6'd21, 32'h00000001, 0, 10);

    // Flush on the tenth CALC edge: nothing may come out
    issue(3'b000, 32'h3, 32'h4, 6'd22);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // A request coinciding with flush is dropped
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3; rd = 6'd23;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("flush_req_drop", {63'd0, busy}, 64'd0);

    // Reset in the middle of CALC
    issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 6'd24);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_out_data", {32'd0, out_data}, 64'd0);
    chk("mrst_out_rd", {58'd0, out_rd}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    run_op("post_rst", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd13, 32'hFFFFFFFE, 0, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
